ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 215 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Holds the ID/EX register, the ALU, the data-SRAM request logic, the HI/LO
// registers with a single-cycle multiplier and a 32-step restoring divider.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         ex_wreg,
    output logic [4:0]   ex_waddr,
    output logic [31:0]  ex_wdata,
    output logic         ex_opl,
    output logic         stallreq_for_ex
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    logic [158:0] r_bus;
    logic [31:0]  r_hi, r_lo;
    div_state_t   r_state;
    logic [4:0]   r_cnt;
    logic [31:0]  r_quo, r_rem, r_dvs;
    logic         r_qneg, r_rneg;

    logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel1;
    logic [3:0]  w_sel2;
    logic        w_ram_en, w_sel_rf_res, w_bus_we;
    logic [3:0]  w_ram_wen;
    logic [4:0]  w_bus_waddr;

    assign {w_pc, w_inst, w_alu_op, w_sel1, w_sel2, w_ram_en, w_ram_wen,
            w_bus_we, w_bus_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_bus;

    // ID/EX register: bubble when ID stalls but EX moves on, hold when both stall
    always_ff @(posedge clk) begin
        if (rst)                       r_bus <= '0;
        else if (stall[2] && !stall[3]) r_bus <= '0;
        else if (!stall[2])            r_bus <= id_to_ex_bus;
    end

    logic [31:0] w_src1, w_src2, w_sum, w_alu;

    // operand selection
    always_comb begin
        w_src1 = '0;
        if (w_sel1[0])      w_src1 = w_rdata1;
        else if (w_sel1[1]) w_src1 = w_pc;
        else if (w_sel1[2]) w_src1 = {27'b0, w_inst[10:6]};
        w_src2 = '0;
        if (w_sel2[0])      w_src2 = w_rdata2;
        else if (w_sel2[1]) w_src2 = {{16{w_inst[15]}}, w_inst[15:0]};
        else if (w_sel2[2]) w_src2 = 32'd8;
        else if (w_sel2[3]) w_src2 = {16'b0, w_inst[15:0]};
    end

    assign w_sum = w_src1 + w_src2;

    // ALU, one-hot operation select
    always_comb begin
        w_alu = '0;
        if (w_alu_op[11])     w_alu = w_sum;
        else if (w_alu_op[10]) w_alu = w_src1 - w_src2;
        else if (w_alu_op[9])  w_alu = {31'b0, $signed(w_src1) < $signed(w_src2)};
        else if (w_alu_op[8])  w_alu = {31'b0, w_src1 < w_src2};
        else if (w_alu_op[7])  w_alu = w_src1 & w_src2;
        else if (w_alu_op[6])  w_alu = ~(w_src1 | w_src2);
        else if (w_alu_op[5])  w_alu = w_src1 | w_src2;
        else if (w_alu_op[4])  w_alu = w_src1 ^ w_src2;
        else if (w_alu_op[3])  w_alu = w_src2 << w_src1[4:0];
        else if (w_alu_op[2])  w_alu = w_src2 >> w_src1[4:0];
        else if (w_alu_op[1])  w_alu = $signed(w_src2) >>> w_src1[4:0];
        else if (w_alu_op[0])  w_alu = {w_src2[15:0], 16'h0};
    end

    logic       w_is_store;
    logic [3:0] w_wen;
    logic [31:0] w_wdata;

    assign w_is_store = w_ram_en && (w_inst[31:29] == 3'b101);

    // store byte strobes and lane replication (inst[27:26]: 00 sb, 01 sh, 11 sw)
    always_comb begin
        w_wen   = '0;
        w_wdata = w_rdata2;
        if (w_is_store) begin
            case (w_inst[27:26])
                2'b00: begin
                    w_wen   = 4'b0001 << w_sum[1:0];
                    w_wdata = {4{w_rdata2[7:0]}};
                end
                2'b01: begin
                    w_wen   = 4'b0011 << {w_sum[1], 1'b0};
                    w_wdata = {2{w_rdata2[15:0]}};
                end
                default: w_wen = 4'b1111;
            endcase
        end
    end

    logic w_special, w_mult, w_multu, w_div, w_divu, w_mfhi, w_mflo, w_mthi, w_mtlo;
    assign w_special = (w_inst[31:26] == 6'b0);
    assign w_mult    = w_special && (w_inst[5:0] == 6'h18);
    assign w_multu   = w_special && (w_inst[5:0] == 6'h19);
    assign w_div     = w_special && (w_inst[5:0] == 6'h1A);
    assign w_divu    = w_special && (w_inst[5:0] == 6'h1B);
    assign w_mfhi    = w_special && (w_inst[5:0] == 6'h10);
    assign w_mflo    = w_special && (w_inst[5:0] == 6'h12);
    assign w_mthi    = w_special && (w_inst[5:0] == 6'h11);
    assign w_mtlo    = w_special && (w_inst[5:0] == 6'h13);

    // Sign-extending both operands to 64 bits makes the low half of an
    // unsigned multiply equal to the signed product.
    logic [63:0] w_prod_s, w_prod_u;
    assign w_prod_s = {{32{w_rdata1[31]}}, w_rdata1} * {{32{w_rdata2[31]}}, w_rdata2};
    assign w_prod_u = {32'b0, w_rdata1} * {32'b0, w_rdata2};

    logic        w_div_go, w_ge;
    logic [31:0] w_abs_a, w_abs_b, w_quo, w_remv;
    logic [32:0] w_shift;
    logic [33:0] w_trial;

    assign w_div_go = (w_div || w_divu) && (w_rdata2 != 32'b0);
    assign w_abs_a  = (w_div && w_rdata1[31]) ? -w_rdata1 : w_rdata1;
    assign w_abs_b  = (w_div && w_rdata2[31]) ? -w_rdata2 : w_rdata2;
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_trial  = {1'b0, w_shift} - {2'b0, r_dvs};
    assign w_ge     = !w_trial[33];
    assign w_quo    = r_qneg ? -r_quo : r_quo;
    assign w_remv   = r_rneg ? -r_rem : r_rem;

    assign stallreq_for_ex = ((r_state == S_IDLE) && w_div_go) || (r_state == S_BUSY);

    // divider FSM: latch magnitudes, 32 restoring steps, wait in DONE for the commit edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_div_go) begin
                    r_quo   <= w_abs_a;
                    r_dvs   <= w_abs_b;
                    r_rem   <= '0;
                    r_qneg  <= w_div && (w_rdata1[31] ^ w_rdata2[31]);
                    r_rneg  <= w_div && w_rdata1[31];
                    r_cnt   <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_rem <= w_ge ? w_trial[31:0] : w_shift[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_DONE;
                end
                S_DONE: if (!stall[3]) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // HI/LO update, only on a cycle where EX advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!stall[3]) begin
            if (r_state == S_DONE) begin
                r_hi <= w_remv;
                r_lo <= w_quo;
            end else if (w_mult) begin
                {r_hi, r_lo} <= w_prod_s;
            end else if (w_multu) begin
                {r_hi, r_lo} <= w_prod_u;
            end else if (w_mthi) begin
                r_hi <= w_rdata1;
            end else if (w_mtlo) begin
                r_lo <= w_rdata1;
            end
        end
    end

    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_result;

    assign w_rf_we    = (w_mfhi || w_mflo) ? 1'b1 : w_bus_we;
    assign w_rf_waddr = (w_mfhi || w_mflo) ? w_inst[15:11] : w_bus_waddr;
    assign w_result   = w_mfhi ? r_hi : (w_mflo ? r_lo : w_alu);

    assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_result};
    assign data_sram_en    = w_ram_en;
    assign data_sram_wen   = w_wen;
    assign data_sram_addr  = w_sum;
    assign data_sram_wdata = w_wdata;
    assign ex_wreg         = w_rf_we;
    assign ex_waddr        = w_rf_waddr;
    assign ex_wdata        = w_result;
    assign ex_opl          = w_sel_rf_res;

    logic w_unused;
    assign w_unused = ^{stall[5:4], stall[1:0], w_inst[25:16], w_trial[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with a minimal stall controller model.
module tb_ex_stage;

    logic         clk, rst;
    logic [5:0]   tb_stall, stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         ex_wreg;
    logic [4:0]   ex_waddr;
    logic [31:0]  ex_wdata;
    logic         ex_opl, stallreq_for_ex;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // an EX stall request freezes IF..EX/MEM, as the pipeline controller does
    assign stall = tb_stall | (stallreq_for_ex ? 6'b001111 : 6'b000000);

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .ex_opl(ex_opl), .stallreq_for_ex(stallreq_for_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren,
                                        input logic [3:0] rwen, input logic we,
                                        input logic [4:0] wa, input logic selr,
                                        input logic [31:0] a, input logic [31:0] b);
        return {pc, inst, op, s1, s2, ren, rwen, we, wa, selr, a, b};
    endfunction

    // R-type with only the function field set; rs/rt values come via rdata
    function automatic logic [158:0] rop(input logic [5:0] func, input logic [4:0] rd,
                                         input logic [31:0] a, input logic [31:0] b);
        return mk(32'h0, {16'b0, rd, 5'b0, func}, 12'h0, 3'b0, 4'b0, 1'b0, 4'b0,
                  1'b0, 5'd0, 1'b0, a, b);
    endfunction

    task automatic issue(input logic [158:0] b);
        id_to_ex_bus = b;
        tick();
    endtask

    task automatic alu_vec(input string tag, input logic [11:0] op, input logic [2:0] s1,
                           input logic [3:0] s2, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        issue(mk(pc, inst, op, s1, s2, 1'b0, 4'b0, 1'b1, 5'd9, 1'b0, a, b));
        chk(tag, ex_wdata, exp);
    endtask

    // issue mfhi (rd 4) and mflo (rd 3) and check the HI/LO values they return
    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        issue(rop(6'h10, 5'd4, 32'h0, 32'h0));
        chk({tag, "_hi"}, {ex_wreg, ex_waddr, ex_wdata}, {1'b1, 5'd4, hi});
        issue(rop(6'h12, 5'd3, 32'h0, 32'h0));
        chk({tag, "_lo"}, {ex_wreg, ex_waddr, ex_wdata}, {1'b1, 5'd3, lo});
    endtask

    // issue a divide, return how many cycles stallreq stayed high
    task automatic run_div(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b,
                           output int unsigned n);
        issue(rop(func, 5'd0, a, b));
        id_to_ex_bus = rop(6'h00, 5'd0, 32'h0, 32'h0);
        n = 0;
        while (stallreq_for_ex === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    logic [158:0] w_sb, w_sh, w_sw, w_lw;
    int unsigned  n_stall;

    initial begin
        w_sb = mk(32'hBFC00010, 32'hA0000003, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0001,
                  1'b0, 5'd0, 1'b0, 32'h100, 32'hAB);
        w_sh = mk(32'hBFC00014, 32'hA4000002, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0011,
                  1'b0, 5'd0, 1'b0, 32'h100, 32'h1234ABCD);
        w_sw = mk(32'hBFC00018, 32'hAC000000, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b1111,
                  1'b0, 5'd0, 1'b0, 32'h200, 32'hDEADBEEF);
        w_lw = mk(32'hBFC0001C, 32'h8C000004, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b1111,
                  1'b1, 5'd7, 1'b1, 32'h300, 32'h0);

        // reset with a live store on the input bus
        rst = 1'b1;
        tb_stall = 6'b0;
        id_to_ex_bus = w_sb;
        tick();
        chk("rst_bus", ex_to_mem_bus, 76'h0);
        chk("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 69'h0);
        chk("rst_misc", {ex_wreg, ex_waddr, ex_wdata, ex_opl, stallreq_for_ex}, 40'h0);
        rst = 1'b0;

        // addiu: 5 + sext(0xFFFF) = 4
        issue(mk(32'hBFC00000, 32'h2405FFFF, 12'h800, 3'b001, 4'b0010, 1'b0, 4'b0,
                 1'b1, 5'd8, 1'b0, 32'd5, 32'h0));
        chk("addiu_fwd", {ex_wreg, ex_waddr, ex_wdata}, {1'b1, 5'd8, 32'd4});
        chk("addiu_bus", ex_to_mem_bus, {32'hBFC00000, 1'b0, 4'b0, 1'b0, 1'b1, 5'd8, 32'd4});

        // bubble insertion
        tb_stall = 6'b000111;
        issue(w_sw);
        chk("bubble", {ex_to_mem_bus, data_sram_en}, 77'h0);
        tb_stall = 6'b0;

        // stores
        issue(w_sb);
        chk("sb", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {1'b1, 4'b1000, 32'h103, 32'hABABABAB});
        tb_stall = 6'b001111;
        issue(w_sw);
        chk("sb_hold", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {1'b1, 4'b1000, 32'h103, 32'hABABABAB});
        tb_stall = 6'b0;
        issue(w_sh);
        chk("sh", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {1'b1, 4'b1100, 32'h102, 32'hABCDABCD});
        issue(w_sw);
        chk("sw", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {1'b1, 4'b1111, 32'h200, 32'hDEADBEEF});

        // load
        issue(w_lw);
        chk("lw_opl", {ex_opl, data_sram_en, data_sram_wen, data_sram_addr}, {1'b1, 1'b1, 4'b0, 32'h304});
        chk("lw_bus", ex_to_mem_bus[43:37], {1'b1, 4'b1111, 1'b1, 1'b1});

        // ALU operations
        alu_vec("sub",   12'h400, 3'b001, 4'b0001, 32'h0, 32'h0, 32'd5, 32'd7, 32'hFFFFFFFE);
        alu_vec("slt",   12'h200, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd1);
        alu_vec("sltu0", 12'h100, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd0);
        alu_vec("sltu1", 12'h100, 3'b001, 4'b0001, 32'h0, 32'h0, 32'd1, 32'hFFFFFFFF, 32'd1);
        alu_vec("and",   12'h080, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 32'hF000);
        alu_vec("nor",   12'h040, 3'b001, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
        alu_vec("or",    12'h020, 3'b001, 4'b0001, 32'h0, 32'h0, 32'h0F, 32'hF0, 32'hFF);
        alu_vec("xor",   12'h010, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFF, 32'h0F, 32'hF0);
        alu_vec("sll",   12'h008, 3'b100, 4'b0001, 32'h0, 32'h00000100, 32'h0, 32'd1, 32'd16);
        alu_vec("srl",   12'h004, 3'b001, 4'b0001, 32'h0, 32'h0, 32'd4, 32'h80000000, 32'h08000000);
        alu_vec("sra",   12'h002, 3'b001, 4'b0001, 32'h0, 32'h0, 32'd4, 32'h80000000, 32'hF8000000);
        alu_vec("lui",   12'h001, 3'b000, 4'b1000, 32'h0, 32'h3C011234, 32'h0, 32'h0, 32'h12340000);
        alu_vec("pc8",   12'h800, 3'b010, 4'b0100, 32'hBFC00000, 32'h0, 32'h0, 32'h0, 32'hBFC00008);
        alu_vec("noop",  12'h000, 3'b001, 4'b0001, 32'h0, 32'h0, 32'd5, 32'd7, 32'h0);

        // multiplies
        issue(rop(6'h19, 5'd0, 32'hFFFFFFFF, 32'd2));
        read_hilo("multu", 32'h1, 32'hFFFFFFFE);
        issue(rop(6'h18, 5'd0, 32'hFFFFFFFE, 32'd3));
        read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        // signed divide -7 / 2
        run_div(6'h1A, 32'hFFFFFFF9, 32'd2, n_stall);
        chk("div_stall", 76'(n_stall), 76'd33);
        read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // unsigned divide by one
        run_div(6'h1B, 32'hFFFFFFFF, 32'd1, n_stall);
        chk("divu_stall", 76'(n_stall), 76'd33);
        read_hilo("divu", 32'h0, 32'hFFFFFFFF);

        // divide by zero leaves HI/LO untouched
        issue(rop(6'h11, 5'd0, 32'h13572468, 32'h0));
        issue(rop(6'h1A, 5'd0, 32'd9, 32'd0));
        chk("div0_nostall", {75'h0, stallreq_for_ex}, 76'h0);
        read_hilo("div0", 32'h13572468, 32'hFFFFFFFF);

        // reset in the middle of a division
        issue(rop(6'h1A, 5'd0, 32'd100, 32'd3));
        id_to_ex_bus = rop(6'h10, 5'd4, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("busy_c10", {75'h0, stallreq_for_ex}, 76'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_div", {75'h0, stallreq_for_ex}, 76'h0);
        read_hilo("post_rst", 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
